// File: rtl/usb_crc_pkg.sv
// Shared types and constants for the USB serial CRC engine.
package usb_crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } crc_state_t;

  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

endpackage

// File: rtl/usb_crc_lfsr.sv
// Remainder register of the serial CRC: preload to all ones, shift one bit per enable.
// r_next is the value the register takes if the current bit_in is shifted in.
module usb_crc_lfsr #(
  parameter int          WIDTH = 16,
  parameter logic [15:0] POLY  = 16'h8005
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             preload,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] r_next
);

  localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             fb_s;

  // Feedback shift and register next-state selection.
  always_comb begin
    fb_s   = r_q[WIDTH-1] ^ bit_in;
    r_next = {r_q[WIDTH-2:0], 1'b0} ^ (fb_s ? POLY_W : {WIDTH{1'b0}});
    if (preload) begin
      r_d = {WIDTH{1'b1}};
    end else if (shift_en) begin
      r_d = r_next;
    end else begin
      r_d = r_q;
    end
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= {WIDTH{1'b1}};
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/usb_crc_engine.sv
// Parametrised serial CRC engine (CRC5/CRC16) with length-framed input and serial result.
// Define USB_CRC_CHECK_EN to add check mode (mode_chk / check_ok ports).
module usb_crc_engine
  import usb_crc_pkg::*;
#(
  parameter int          WIDTH   = 16,
  parameter logic [15:0] POLY    = CRC16_POLY,
  parameter logic [15:0] RESIDUE = CRC16_RESIDUE,
  parameter int          LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             crc_out,
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic [WIDTH-1:0] crc_val,
  output logic             done,
  input  logic             ack,
`ifdef USB_CRC_CHECK_EN
  input  logic             mode_chk,
  output logic             check_ok,
`endif
  output logic             busy
);

  localparam int             IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  crc_state_t       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] bit_sel_s;
  logic [WIDTH-1:0] crc_val_q, crc_val_d;
  logic [WIDTH-1:0] r_next_s;
  logic             preload_s;
  logic             shift_en_s;
  logic             start_acc_s;
  logic             last_bit_s;
  logic             ack_acc_s;
  logic             mode_in_s;
  logic             chk_mode_s;

  usb_crc_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .preload  (preload_s),
    .shift_en (shift_en_s),
    .bit_in   (bit_in),
    .r_next   (r_next_s)
  );

  // Control FSM: next state, counters and result latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    crc_val_d   = crc_val_q;
    preload_s   = 1'b0;
    shift_en_s  = 1'b0;
    start_acc_s = 1'b0;
    last_bit_s  = 1'b0;
    ack_acc_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          preload_s   = 1'b1;
          cnt_d       = msg_len;
          idx_d       = {IDX_W{1'b0}};
          if (msg_len == {LEN_W{1'b0}}) begin
            // Empty message: result is the complemented preload.
            crc_val_d = {WIDTH{1'b0}};
            state_d   = mode_in_s ? ST_DONE : ST_EMIT;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_valid) begin
          shift_en_s = 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            last_bit_s = 1'b1;
            cnt_d      = {LEN_W{1'b0}};
            crc_val_d  = ~r_next_s;
            state_d    = chk_mode_s ? ST_DONE : ST_EMIT;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_EMIT: begin
        if (crc_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        if (ack) begin
          ack_acc_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and latched result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {LEN_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      crc_val_q <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      crc_val_q <= crc_val_d;
    end
  end

`ifdef USB_CRC_CHECK_EN
  localparam logic [WIDTH-1:0] RES_W = RESIDUE[WIDTH-1:0];

  logic mode_q, mode_d;
  logic check_ok_q, check_ok_d;

  assign mode_in_s  = mode_chk;
  assign chk_mode_s = mode_q;

  // Check-mode capture and residual compare on entry to DONE.
  always_comb begin
    mode_d     = mode_q;
    check_ok_d = check_ok_q;
    if (start_acc_s) begin
      mode_d = mode_chk;
      if (mode_chk && (msg_len == {LEN_W{1'b0}})) begin
        check_ok_d = ({WIDTH{1'b1}} == RES_W);
      end else begin
        check_ok_d = 1'b0;
      end
    end else if (last_bit_s && mode_q) begin
      check_ok_d = (r_next_s == RES_W);
    end else if (ack_acc_s) begin
      check_ok_d = 1'b0;
    end else begin
      check_ok_d = check_ok_q;
    end
  end

  // Check-mode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 1'b0;
      check_ok_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      check_ok_q <= check_ok_d;
    end
  end

  assign check_ok = check_ok_q;
`else
  assign mode_in_s  = 1'b0;
  assign chk_mode_s = 1'b0;
`endif

  assign bit_sel_s = IDX_LAST - idx_q;
  assign crc_out   = (state_q == ST_EMIT) ? crc_val_q[bit_sel_s] : 1'b0;
  assign crc_valid = (state_q == ST_EMIT);
  assign bit_ready = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign crc_val   = crc_val_q;

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed self-checking bench for usb_crc_engine (CRC16 and CRC5 instances).
module tb_usb_crc_engine;
  import usb_crc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, crc_ready = 1'b0, ack = 1'b0;
  logic [7:0]  msg_len = 8'd0;
  logic        bit_ready, crc_out, crc_valid, done, busy;
  logic [15:0] crc_val;
  logic        mode_chk = 1'b0;
  logic        check_ok;

  logic        start5 = 1'b0, bin5 = 1'b0, bv5 = 1'b0, crdy5 = 1'b0, ack5 = 1'b0;
  logic [7:0]  len5 = 8'd0;
  logic        brdy5, cout5, cvalid5, done5, busy5;
  logic [4:0]  cval5;
  logic        mode5 = 1'b0;
  logic        ok5;

  logic [15:0] seq;
  logic        all_valid;
  logic [4:0]  seq5;

  always #5 clk = ~clk;

  usb_crc_engine #(.WIDTH(16), .POLY(CRC16_POLY), .RESIDUE(CRC16_RESIDUE), .LEN_W(8)) u16 (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .crc_out(crc_out), .crc_valid(crc_valid),
    .crc_ready(crc_ready), .crc_val(crc_val), .done(done), .ack(ack),
`ifdef USB_CRC_CHECK_EN
    .mode_chk(mode_chk), .check_ok(check_ok),
`endif
    .busy(busy)
  );

  usb_crc_engine #(.WIDTH(5), .POLY({11'd0, CRC5_POLY}), .RESIDUE({11'd0, CRC5_RESIDUE}), .LEN_W(8)) u5 (
    .clk(clk), .rst(rst), .start(start5), .msg_len(len5), .bit_in(bin5),
    .bit_valid(bv5), .bit_ready(brdy5), .crc_out(cout5), .crc_valid(cvalid5),
    .crc_ready(crdy5), .crc_val(cval5), .done(done5), .ack(ack5),
`ifdef USB_CRC_CHECK_EN
    .mode_chk(mode5), .check_ok(ok5),
`endif
    .busy(busy5)
  );

`ifndef USB_CRC_CHECK_EN
  assign check_ok = 1'b0;
  assign ok5      = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_msg(input logic [31:0] bits, input int n, input logic chk);
    start    = 1'b1;
    msg_len  = 8'(n);
    mode_chk = chk;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit_in    = bits[n-1-i];
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic drain(input int w, output logic [15:0] s, output logic v);
    s = 16'd0;
    v = 1'b1;
    crc_ready = 1'b1;
    for (int i = 0; i < w; i++) begin
      s[w-1-i] = crc_out;
      v = v & crc_valid;
      if (i == w - 1) check("done_before_last", {15'd0, done}, 16'd0);
      tick();
    end
    crc_ready = 1'b0;
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_bit_ready", {15'd0, bit_ready}, 16'd0);
    check("rst_crc_valid", {15'd0, crc_valid}, 16'd0);
    check("rst_crc_out", {15'd0, crc_out}, 16'd0);
    check("rst_crc_val", crc_val, 16'h0000);
    check("rst_check_ok", {15'd0, check_ok}, 16'd0);

    // One '1' bit, CRC16.
    start   = 1'b1;
    msg_len = 8'd1;
    tick();
    start = 1'b0;
    check("start_to_bit_ready", {15'd0, bit_ready}, 16'd1);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("t1_crc_valid", {15'd0, crc_valid}, 16'd1);
    check("t1_crc_val", crc_val, 16'h0001);
    drain(16, seq, all_valid);
    check("t1_seq", seq, 16'h0001);
    check("t1_valid_held", {15'd0, all_valid}, 16'd1);
    check("t1_done", {15'd0, done}, 16'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_idle_after_ack", {15'd0, busy}, 16'd0);

    // One '0' bit, CRC16; ack with start must not start a message.
    send_msg(32'h0, 1, 1'b0);
    check("t2_crc_val", crc_val, 16'h8004);
    drain(16, seq, all_valid);
    check("t2_seq", seq, 16'h8004);
    check("t2_done", {15'd0, done}, 16'd1);
    ack   = 1'b1;
    start = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check("t2_ack_start_idle", {15'd0, busy}, 16'd0);
    tick();
    check("t2_still_idle", {15'd0, busy}, 16'd0);
    check("t2_val_held", crc_val, 16'h8004);

    // CRC5, one '1' bit.
    start5 = 1'b1;
    len5   = 8'd1;
    tick();
    start5 = 1'b0;
    bin5   = 1'b1;
    bv5    = 1'b1;
    tick();
    bv5 = 1'b0;
    check("t3_crc5_val", {11'd0, cval5}, 16'h0001);
    crdy5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      seq5[4-i] = cout5;
      tick();
    end
    crdy5 = 1'b0;
    check("t3_crc5_seq", {11'd0, seq5}, 16'h0001);
    check("t3_crc5_done", {15'd0, done5}, 16'd1);
    ack5 = 1'b1;
    tick();
    ack5 = 1'b0;
    check("t3_crc5_idle", {15'd0, busy5}, 16'd0);

    // Empty message, then stall in EMIT.
    start   = 1'b1;
    msg_len = 8'd0;
    tick();
    start = 1'b0;
    check("t4_emit_next", {15'd0, crc_valid}, 16'd1);
    check("t4_crc_val", crc_val, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      bit_valid = ~bit_valid;
      bit_in    = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check("t4_stall_valid", {15'd0, crc_valid}, 16'd1);
    check("t4_stall_not_done", {15'd0, done}, 16'd0);
    drain(16, seq, all_valid);
    check("t4_seq", seq, 16'h0000);
    check("t4_valid_held", {15'd0, all_valid}, 16'd1);
    check("t4_done", {15'd0, done}, 16'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

`ifdef USB_CRC_CHECK_EN
    // Check mode: good and corrupted frames.
    send_msg(32'h0001_0001, 17, 1'b1);
    check("t5_good_done", {15'd0, done}, 16'd1);
    check("t5_good_ok", {15'd0, check_ok}, 16'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    send_msg(32'h0000_0001, 17, 1'b1);
    check("t5_bad_done", {15'd0, done}, 16'd1);
    check("t5_bad_ok", {15'd0, check_ok}, 16'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    mode_chk = 1'b0;
`endif

    // Reset after 3 of 8 bits, then a clean run of 8'hA5.
    start   = 1'b1;
    msg_len = 8'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_in    = (i != 1);
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_abort_idle", {15'd0, busy}, 16'd0);
    check("t6_abort_ready", {15'd0, bit_ready}, 16'd0);
    send_msg(32'h0000_00A5, 8, 1'b0);
    check("t6_crc_val", crc_val, 16'h0123);
    drain(16, seq, all_valid);
    check("t6_seq", seq, 16'h0123);
    check("t6_done", {15'd0, done}, 16'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_crc_engine.md
# usb_crc_engine

Parametrised serial CRC engine for the USB receive and transmit paths, replacing the fixed 16-bit CRC unit. One instance covers both CRC5 (token) and CRC16 (data) through the width and polynomial parameters. It accepts a length-framed serial bit stream with a valid/ready handshake and computes the complemented remainder. It then emits that remainder serially, MSB first, and holds it until the packet layer acknowledges.

## Interface
- WIDTH, 16, CRC width; legal range 2..16 (5 for tokens, 16 for data)
- POLY, 16'h8005, generator polynomial without the x^WIDTH term; only bits [WIDTH-1:0] are used
- RESIDUE, 16'h800D, expected check-mode residual; only bits [WIDTH-1:0] are used (use 5'h0C for CRC5)
- LEN_W, 8, width of the message-length field
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begins a message; sampled only in IDLE
- msg_len  in  LEN_W  number of message bits; captured on start
- bit_in  in  1  serial message bit, in wire order
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  engine accepts a bit this cycle; high only in SHIFT
- crc_out  out  1  serial CRC bit; MSB of crc_val first
- crc_valid  out  1  crc_out is valid; high only in EMIT
- crc_ready  in  1  consumer takes crc_out this cycle
- crc_val  out  WIDTH  latched complemented remainder
- done  out  1  result available; high in DONE
- ack  in  1  consumer has taken the result; returns the engine to IDLE
- busy  out  1  high in every state except IDLE
- mode_chk  in  1  captured on start: 0 = generate, 1 = check (only with USB_CRC_CHECK_EN)
- check_ok  out  1  residual matched RESIDUE (only with USB_CRC_CHECK_EN)

## Operation
- States: IDLE, SHIFT, EMIT, DONE.
- IDLE
  - On start: go to SHIFT, preload the remainder register to all ones, capture msg_len into the bit counter, capture mode_chk.
  - If msg_len == 0: go directly to EMIT, or to DONE in check mode.
- SHIFT
  - A bit is accepted when bit_valid && bit_ready.
  - On each accepted bit: fb = r[WIDTH-1] ^ bit_in; r <= {r[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0); the counter decrements.
  - When the last bit is accepted: go to EMIT in generate mode, or DONE in check mode.
  - crc_val <= ~r_next is loaded on the same edge.
- EMIT
  - crc_out = crc_val[WIDTH-1-idx], with idx starting at 0.
  - idx advances on each crc_ready.
  - The transfer with idx == WIDTH-1 moves the engine to DONE.
- DONE
  - done = 1; crc_val is held stable.
  - ack moves the engine to IDLE.
  - start is ignored until the engine has returned to IDLE.
- start, bit_valid and crc_ready are ignored in any state where they have no meaning.
- Counters are LEN_W and $clog2(WIDTH) bits wide and never wrap; the last-bit compare precedes the decrement.

## Timing
- Reset values: state IDLE, r = all ones; every output is 0, including crc_val and check_ok.
- start to bit_ready high: 1 cycle.
- Throughput: one message bit per cycle when bit_valid is held high.
- Latency from the last accepted bit to crc_valid: 1 cycle. The first crc_out is valid in that same cycle.
- done rises one cycle after the final EMIT transfer, or after the final message bit in check mode.
- An ack in DONE gives IDLE on the next cycle. An ack together with start in that cycle does not start a message.
- rst asserted mid-message aborts the operation; the engine is in IDLE with reset values on the next cycle.

## Configuration
- USB_CRC_CHECK_EN defined:
  - The mode_chk and check_ok ports exist.
  - Check mode: msg_len includes the received CRC bits; EMIT is skipped.
  - check_ok = (r[WIDTH-1:0] == RESIDUE[WIDTH-1:0]) is registered on entry to DONE and held until ack.
- USB_CRC_CHECK_EN undefined:
  - The mode_chk and check_ok ports are absent.
  - Generate mode only.

## Structure
- Package usb_crc_pkg holds:
  - the state enum crc_state_t;
  - constants CRC5_POLY = 5'h05, CRC5_RESIDUE = 5'h0C, CRC16_POLY = 16'h8005, CRC16_RESIDUE = 16'h800D.
- Sub-module usb_crc_lfsr #(WIDTH, POLY) holds the remainder register with preload, shift-enable and the next-state output. The FSM and counters stay in the top level.

## Test plan
- WIDTH=16, start with msg_len=1, bit_in=1 -> crc_val = 16'h0001; crc_out sequence is 15 zeros then 1; done one cycle after the 16th crc_ready.
- WIDTH=16, msg_len=1, bit_in=0 -> crc_val = 16'h8004.
- WIDTH=5, POLY=5'h05, msg_len=1, bit_in=1 -> crc_val = 5'h01.
- msg_len=0 -> EMIT entered the cycle after start; crc_val = 0; bit_valid toggling and crc_ready held low for 5 cycles -> crc_out stalls with no state change.
- With USB_CRC_CHECK_EN, check mode:
  - 17 bits (1, then 16'h0001 MSB first) -> check_ok = 1;
  - the same stream with one bit flipped -> check_ok = 0.
- rst pulsed after 3 of 8 bits, then a fresh start -> the result matches a clean run with the same 8 bits.
